// File: rtl/mem_burst_tester_if.sv
// Burst interface between the traffic tester and the mem_burst_v2 controller.
// Write side: request/length/address out, data out, data_req in.
// Read side: request/length/address out, data/valid in. burst_finish ends either burst.
interface mem_burst_tester_if #(
   parameter int MEM_DATA_BITS = 128,
   parameter int ADDR_BITS     = 24,
   parameter int LEN_BITS      = 10
);
   logic                     wr_burst_req;
   logic [LEN_BITS-1:0]      wr_burst_len;
   logic [ADDR_BITS-1:0]     wr_burst_addr;
   logic [MEM_DATA_BITS-1:0] wr_burst_data;
   logic                     wr_burst_data_req;
   logic                     rd_burst_req;
   logic [LEN_BITS-1:0]      rd_burst_len;
   logic [ADDR_BITS-1:0]     rd_burst_addr;
   logic [MEM_DATA_BITS-1:0] rd_burst_data;
   logic                     rd_burst_data_valid;
   logic                     burst_finish;

   // tester side
   modport master (
      output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
      output rd_burst_req, rd_burst_len, rd_burst_addr,
      input  wr_burst_data_req, rd_burst_data, rd_burst_data_valid, burst_finish
   );

   // controller side
   modport slave (
      input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
      input  rd_burst_req, rd_burst_len, rd_burst_addr,
      output wr_burst_data_req, rd_burst_data, rd_burst_data_valid, burst_finish
   );
endinterface

// File: rtl/mem_burst_tester.sv
// Write/read-back burst traffic generator and checker: write one pattern burst, read it back, compare beats.
// Latency: pattern data is combinational from the beat count; err/err_cnt register one cycle after the bad beat.
// Backpressure: write beats advance only on wr_burst_data_req, read beats only on rd_burst_data_valid.
module mem_burst_tester #(
   parameter int          MEM_DATA_BITS = 128,
   parameter int          ADDR_BITS     = 24,
   parameter int          LEN_BITS      = 10,
   parameter int          BURST_LEN     = 128,
   parameter int unsigned ADDR_STEP     = 128,
   parameter int unsigned ADDR_LIMIT    = 32'h0080_0000,
   parameter int          ERR_BITS      = 16
) (
   input  logic                  mem_clk,
   input  logic                  rst_n,
   input  logic                  local_init_done_i,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic [1:0]            mode_i,
   input  logic [15:0]           num_bursts_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [ERR_BITS-1:0]   err_cnt_o,
   output logic [ADDR_BITS-1:0]  first_err_addr_o,
   output logic [15:0]           pass_cnt_o,
   mem_burst_tester_if.master    mb
);

   localparam int NB   = MEM_DATA_BITS / 8;
   localparam int NW   = MEM_DATA_BITS / 32;
   localparam int PW   = $clog2(MEM_DATA_BITS);
   localparam logic [31:0] LFSR_RST = 32'hACE1_0001;

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_NEXT, S_DONE} state_t;

   state_t                state_q;
   logic [LEN_BITS-1:0]   wbeat_q, rbeat_q;
   logic [ADDR_BITS-1:0]  addr_q;
   logic [15:0]           pass_q;
   logic [15:0]           num_q;
   logic [1:0]            mode_q;
   logic [ERR_BITS-1:0]   err_cnt_q;
   logic [ADDR_BITS-1:0]  first_q;
   logic                  err_q, busy_q, done_q, wr_req_q, rd_req_q, stop_q;
   logic [31:0]           wlfsr_q, rlfsr_q;

   logic [MEM_DATA_BITS-1:0] wr_pat, rd_exp;
   logic                     mismatch, short_rd;
   logic [LEN_BITS:0]        rcount;
   logic [1:0]               err_inc;
   logic [ERR_BITS:0]        err_sum;
   logic [ERR_BITS-1:0]      err_cnt_d;
   logic [31:0]              addr_sum;
   logic [ADDR_BITS-1:0]     addr_d;
   logic                     finish_run;

   // one Fibonacci step of x^32+x^22+x^2+x+1
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   // per-burst LFSR seed derived from the pair index
   function automatic logic [31:0] lfsr_seed(input logic [7:0] b);
      return {b, 24'hCE1001} | 32'd1;
   endfunction

   // beat pattern for pair index b, beat k
   function automatic logic [MEM_DATA_BITS-1:0] pattern_f(input logic [1:0] m, input logic [7:0] b,
                                                          input logic [LEN_BITS-1:0] k, input logic [31:0] lfsr);
      logic [MEM_DATA_BITS-1:0] p;
      logic [7:0]               byt;
      logic [LEN_BITS+7:0]      sum;
      logic [PW-1:0]            pos;
      sum = {8'd0, k} + {{LEN_BITS{1'b0}}, b};
      byt = sum[7:0];
      pos = sum[PW-1:0];
      case (m)
         2'd0:    p = {NB{byt}};
         2'd1:    p = {{(MEM_DATA_BITS-1){1'b0}}, 1'b1} << pos;
         2'd2:    p = {NW{lfsr}};
         default: p = ~{NB{byt}};
      endcase
      return p;
   endfunction

   // pattern generation, beat check, saturating error count and next burst address
   always_comb begin
      wr_pat    = pattern_f(mode_q, pass_q[7:0], wbeat_q, wlfsr_q);
      rd_exp    = pattern_f(mode_q, pass_q[7:0], rbeat_q, rlfsr_q);
      mismatch  = (state_q == S_RD) && mb.rd_burst_data_valid && (mb.rd_burst_data != rd_exp);
      rcount    = {1'b0, rbeat_q} + {{LEN_BITS{1'b0}}, mb.rd_burst_data_valid};
      short_rd  = (state_q == S_RD) && mb.burst_finish && (rcount != (LEN_BITS+1)'(BURST_LEN));
      err_inc   = {1'b0, mismatch} + {1'b0, short_rd};
      err_sum   = {1'b0, err_cnt_q} + {{(ERR_BITS-1){1'b0}}, err_inc};
      err_cnt_d = err_sum[ERR_BITS] ? {ERR_BITS{1'b1}} : err_sum[ERR_BITS-1:0];
      addr_sum  = 32'(addr_q) + ADDR_STEP;
      addr_d    = (addr_sum >= ADDR_LIMIT) ? '0 : addr_sum[ADDR_BITS-1:0];
      finish_run = stop_q || stop_i || ((num_q != 16'd0) && ((pass_q + 16'd1) == num_q));
   end

   // test sequencer: write burst, read burst, advance, with abort on loss of calibration
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         wbeat_q   <= '0;
         rbeat_q   <= '0;
         addr_q    <= '0;
         pass_q    <= '0;
         num_q     <= '0;
         mode_q    <= '0;
         err_cnt_q <= '0;
         first_q   <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_req_q  <= 1'b0;
         rd_req_q  <= 1'b0;
         stop_q    <= 1'b0;
         wlfsr_q   <= LFSR_RST;
         rlfsr_q   <= LFSR_RST;
      end else begin
         err_q <= 1'b0;
         if (!local_init_done_i) begin
            state_q  <= S_IDLE;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            busy_q   <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE, S_DONE: begin
                  if (start_i) begin
                     state_q   <= S_WR;
                     mode_q    <= mode_i;
                     num_q     <= num_bursts_i;
                     pass_q    <= '0;
                     addr_q    <= '0;
                     err_cnt_q <= '0;
                     first_q   <= '0;
                     stop_q    <= 1'b0;
                     busy_q    <= 1'b1;
                     done_q    <= 1'b0;
                     wr_req_q  <= 1'b1;
                     wbeat_q   <= '0;
                     wlfsr_q   <= lfsr_seed(8'd0);
                  end
               end
               S_WR: begin
                  if (stop_i) stop_q <= 1'b1;
                  if (mb.wr_burst_data_req) begin
                     wr_req_q <= 1'b0;
                     wbeat_q  <= wbeat_q + 1'b1;
                     wlfsr_q  <= lfsr_step(wlfsr_q);
                  end
                  if (mb.burst_finish) begin
                     state_q  <= S_RD;
                     wr_req_q <= 1'b0;
                     rd_req_q <= 1'b1;
                     rbeat_q  <= '0;
                     rlfsr_q  <= lfsr_seed(pass_q[7:0]);
                  end
               end
               S_RD: begin
                  if (stop_i) stop_q <= 1'b1;
                  if (mb.rd_burst_data_valid) begin
                     rd_req_q <= 1'b0;
                     rbeat_q  <= rbeat_q + 1'b1;
                     rlfsr_q  <= lfsr_step(rlfsr_q);
                  end
                  if (err_inc != 2'd0) begin
                     err_q     <= 1'b1;
                     err_cnt_q <= err_cnt_d;
                     if (err_cnt_q == '0) first_q <= addr_q + ADDR_BITS'(rbeat_q);
                  end
                  if (mb.burst_finish) begin
                     state_q  <= S_NEXT;
                     rd_req_q <= 1'b0;
                  end
               end
               S_NEXT: begin
                  pass_q <= pass_q + 16'd1;
                  addr_q <= addr_d;
                  if (finish_run) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     stop_q  <= 1'b0;
                  end else begin
                     state_q  <= S_WR;
                     wr_req_q <= 1'b1;
                     wbeat_q  <= '0;
                     wlfsr_q  <= lfsr_seed(pass_q[7:0] + 8'd1);
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign err_o            = err_q;
   assign err_cnt_o        = err_cnt_q;
   assign first_err_addr_o = first_q;
   assign pass_cnt_o       = pass_q;

   assign mb.wr_burst_req  = wr_req_q;
   assign mb.rd_burst_req  = rd_req_q;
   assign mb.wr_burst_len  = LEN_BITS'(BURST_LEN);
   assign mb.rd_burst_len  = LEN_BITS'(BURST_LEN);
   assign mb.wr_burst_addr = addr_q;
   assign mb.rd_burst_addr = addr_q;
   assign mb.wr_burst_data = wr_pat;

endmodule

// File: tb/tb_mem_burst_tester.sv
// Bench for mem_burst_tester: loopback memory responder with random beat gaps,
// an independent pattern/address model, error injection, stop, abort and wrap runs.
module tb_mem_burst_tester;
   localparam int BL    = 128;
   localparam int STEP  = 128;
   localparam int LIMIT = 32'h0080_0000;

   logic mem_clk = 1'b0;
   logic rst_n   = 1'b0;
   always #5 mem_clk = ~mem_clk;

   // main DUT controls and outputs
   logic        init = 1'b0, start = 1'b0, stop = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [15:0] num  = 16'd0;
   logic        busy, done, err;
   logic [15:0] err_cnt, pass_cnt;
   logic [23:0] first_err;

   // wrap DUT controls and outputs
   logic        start2 = 1'b0, stop2 = 1'b0;
   logic [1:0]  mode2 = 2'd0;
   logic [15:0] num2  = 16'd0;
   logic        busy2, done2, err2;
   logic [15:0] err_cnt2, pass_cnt2;
   logic [23:0] first_err2;

   mem_burst_tester_if #(.MEM_DATA_BITS(128), .ADDR_BITS(24), .LEN_BITS(10)) bus1 ();
   mem_burst_tester_if #(.MEM_DATA_BITS(128), .ADDR_BITS(24), .LEN_BITS(10)) bus2 ();

   mem_burst_tester #(.BURST_LEN(BL)) dut (
      .mem_clk(mem_clk), .rst_n(rst_n), .local_init_done_i(init), .start_i(start), .stop_i(stop),
      .mode_i(mode), .num_bursts_i(num), .busy_o(busy), .done_o(done), .err_o(err),
      .err_cnt_o(err_cnt), .first_err_addr_o(first_err), .pass_cnt_o(pass_cnt), .mb(bus1));

   mem_burst_tester #(.BURST_LEN(4), .ADDR_LIMIT(256)) dut2 (
      .mem_clk(mem_clk), .rst_n(rst_n), .local_init_done_i(init), .start_i(start2), .stop_i(stop2),
      .mode_i(mode2), .num_bursts_i(num2), .busy_o(busy2), .done_o(done2), .err_o(err2),
      .err_cnt_o(err_cnt2), .first_err_addr_o(first_err2), .pass_cnt_o(pass_cnt2), .mb(bus2));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference pattern computed from the pattern rules
   function automatic logic [127:0] exp_pat(input int m, input int b, input int k);
      logic [127:0] p;
      logic [7:0]   v;
      logic [31:0]  s;
      p = '0;
      v = 8'((k + b) % 256);
      if (m == 1) begin
         p = 128'd1 << ((k + b) % 128);
      end else if (m == 2) begin
         s = {8'(b), 24'hCE1001} | 32'd1;
         for (int j = 0; j < k; j++) s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
         for (int i = 0; i < 4; i++) p[i*32 +: 32] = s;
      end else begin
         for (int i = 0; i < 16; i++) p[i*8 +: 8] = v;
         if (m == 3) p = ~p;
      end
      return p;
   endfunction

   // state shared from main (written) to the responder (read)
   int tb_mode = 0;
   int pair_base = 0;
   int corrupt_pair = -1, corrupt_beat = 0, short_pair = -1;

   // responder-owned statistics
   int pairs_total = 0, wbad_tot = 0, addr_bad = 0, drop_bad = 0, err_pulses = 0;
   logic [127:0] mem [int];

   // loopback controller model for the main DUT
   initial begin
      int ph, cnt, waitc, rel, rlen, cur;
      logic [127:0] d;
      ph = 0; cnt = 0; waitc = 0; cur = 0;
      bus1.wr_burst_data_req = 1'b0; bus1.rd_burst_data_valid = 1'b0;
      bus1.burst_finish = 1'b0; bus1.rd_burst_data = '0;
      forever begin
         @(posedge mem_clk); #1;
         if (err) err_pulses++;
         bus1.wr_burst_data_req = 1'b0; bus1.rd_burst_data_valid = 1'b0; bus1.burst_finish = 1'b0;
         rel = pairs_total - pair_base;
         if (!init) begin
            ph = 0;
         end else begin
            case (ph)
               0: if (bus1.wr_burst_req) begin
                     if (int'(bus1.wr_burst_addr) != (rel * STEP) % LIMIT) addr_bad++;
                     cur = int'(bus1.wr_burst_addr); cnt = 0; waitc = $urandom_range(0, 3); ph = 1;
                  end
               1: if (waitc > 0) waitc--;
                  else if ($urandom_range(0, 4) != 0) begin
                     bus1.wr_burst_data_req = 1'b1;
                     if (bus1.wr_burst_data !== exp_pat(tb_mode, rel % 256, cnt)) wbad_tot++;
                     mem[cur + cnt] = bus1.wr_burst_data;
                     cnt++;
                     if (cnt == BL) ph = 2;
                  end
               2: begin
                     if (bus1.wr_burst_req) drop_bad++;
                     bus1.burst_finish = 1'b1; ph = 3;
                  end
               3: if (bus1.rd_burst_req) begin
                     if (int'(bus1.rd_burst_addr) != cur) addr_bad++;
                     cnt = 0; ph = 4;
                  end
               4: begin
                     rlen = (rel == short_pair) ? BL - 1 : BL;
                     if ($urandom_range(0, 4) != 0) begin
                        d = mem[cur + cnt];
                        if (rel == corrupt_pair && cnt == corrupt_beat) d[0] = ~d[0];
                        bus1.rd_burst_data = d;
                        bus1.rd_burst_data_valid = 1'b1;
                        cnt++;
                        if (cnt == rlen) ph = 5;
                     end
                  end
               default: begin
                     if (bus1.rd_burst_req) drop_bad++;
                     bus1.burst_finish = 1'b1; pairs_total++; ph = 0;
                  end
            endcase
         end
      end
   end

   // minimal gapless loopback for the wrap DUT; logs each write address
   int a2 [0:7];
   int n2 = 0;
   initial begin
      int ph2, c2;
      logic [127:0] m2 [0:3];
      ph2 = 0; c2 = 0;
      bus2.wr_burst_data_req = 1'b0; bus2.rd_burst_data_valid = 1'b0;
      bus2.burst_finish = 1'b0; bus2.rd_burst_data = '0;
      forever begin
         @(posedge mem_clk); #1;
         bus2.wr_burst_data_req = 1'b0; bus2.rd_burst_data_valid = 1'b0; bus2.burst_finish = 1'b0;
         case (ph2)
            0: if (bus2.wr_burst_req) begin
                  if (n2 < 8) a2[n2] = int'(bus2.wr_burst_addr);
                  n2++; c2 = 0; ph2 = 1;
               end
            1: begin
                  bus2.wr_burst_data_req = 1'b1; m2[c2] = bus2.wr_burst_data; c2++;
                  if (c2 == 4) ph2 = 2;
               end
            2: begin bus2.burst_finish = 1'b1; ph2 = 3; end
            3: if (bus2.rd_burst_req) begin c2 = 0; ph2 = 4; end
            4: begin
                  bus2.rd_burst_data_valid = 1'b1; bus2.rd_burst_data = m2[c2]; c2++;
                  if (c2 == 4) ph2 = 5;
               end
            default: begin bus2.burst_finish = 1'b1; ph2 = 0; end
         endcase
      end
   end

   int base_wbad, base_addr, base_drop, base_pulses;

   // start a run; mode/num are scrambled afterwards, which the DUT must ignore
   task automatic run_start(input int m, input int n);
      @(posedge mem_clk); #2;
      mode = 2'(m); num = 16'(n); tb_mode = m; pair_base = pairs_total;
      base_wbad = wbad_tot; base_addr = addr_bad; base_drop = drop_bad; base_pulses = err_pulses;
      start = 1'b1;
      @(posedge mem_clk); #2;
      start = 1'b0;
      mode = 2'($urandom_range(0, 3)); num = 16'($urandom_range(1, 2));
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      while (!done && c < budget) begin @(posedge mem_clk); #1; c++; end
      chk("done_timeout", done, 1);
   endtask

   // post-run checks common to every completed run
   task automatic run_end(input string tag, input int exp_pass, input int exp_err);
      chk({tag, "_pass"}, pass_cnt, exp_pass);
      chk({tag, "_errcnt"}, err_cnt, exp_err);
      chk({tag, "_pulses"}, err_pulses - base_pulses, exp_err);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_wdata"}, wbad_tot - base_wbad, 0);
      chk({tag, "_addr"}, addr_bad - base_addr, 0);
      chk({tag, "_reqdrop"}, drop_bad - base_drop, 0);
   endtask

   initial begin
      int c, m, n, cp, cb;
      repeat (3) @(posedge mem_clk);
      #2 rst_n = 1'b1;
      @(posedge mem_clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_errcnt", err_cnt, 0);
      chk("rst_pass", pass_cnt, 0);
      chk("rst_wreq", bus1.wr_burst_req, 0);
      chk("rst_rreq", bus1.rd_burst_req, 0);
      chk("rst_wdata", bus1.wr_burst_data, 0);
      chk("burst_len", bus1.wr_burst_len, BL);
      init = 1'b1;

      // plain loopback, three pairs
      run_start(0, 3);
      chk("busy_run", busy, 1);
      wait_done(3000);
      run_end("mode0", 3, 0);

      // corrupt beat 5 of pair 1
      corrupt_pair = 1; corrupt_beat = 5;
      run_start(1, 3);
      wait_done(3000);
      run_end("corrupt", 3, 1);
      chk("first_err_addr", first_err, 133);
      corrupt_pair = -1;

      // free-run LFSR, stop after 10 pairs: the in-flight pair completes
      run_start(2, 0);
      c = 0;
      while (pass_cnt != 16'd10 && c < 6000) begin @(posedge mem_clk); #1; c++; end
      chk("stop_reach10", pass_cnt, 10);
      #1 stop = 1'b1;
      @(posedge mem_clk); #2 stop = 1'b0;
      wait_done(1500);
      run_end("stop", 11, 0);

      // short read burst on pair 0
      short_pair = 0;
      run_start(3, 2);
      wait_done(2000);
      run_end("short", 2, 1);
      short_pair = -1;

      // calibration loss in the middle of a read burst
      run_start(0, 0);
      c = 0;
      while (!bus1.rd_burst_req && c < 1000) begin @(posedge mem_clk); #1; c++; end
      chk("abort_rreq_seen", bus1.rd_burst_req, 1);
      repeat (10) @(posedge mem_clk);
      #2 init = 1'b0;
      @(posedge mem_clk); #1;
      chk("abort_rreq", bus1.rd_burst_req, 0);
      chk("abort_wreq", bus1.wr_burst_req, 0);
      chk("abort_busy", busy, 0);
      repeat (3) @(posedge mem_clk);
      #2 init = 1'b1;
      run_start(0, 2);
      wait_done(2000);
      run_end("restart", 2, 0);

      // randomized runs with optional corruption
      for (int r = 0; r < 3; r++) begin
         m  = $urandom_range(0, 3);
         n  = $urandom_range(1, 3);
         cp = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
         cb = $urandom_range(0, BL - 1);
         corrupt_pair = cp; corrupt_beat = cb;
         run_start(m, n);
         wait_done(3000);
         run_end("rand", n, (cp >= 0) ? 1 : 0);
         if (cp >= 0) chk("rand_first", first_err, cp * STEP + cb);
      end
      corrupt_pair = -1;

      // address wrap with a 256-byte limit
      @(posedge mem_clk); #2;
      mode2 = 2'd0; num2 = 16'd3; start2 = 1'b1;
      @(posedge mem_clk); #2 start2 = 1'b0;
      c = 0;
      while (!done2 && c < 500) begin @(posedge mem_clk); #1; c++; end
      chk("wrap_done", done2, 1);
      chk("wrap_n", n2, 3);
      chk("wrap_a0", a2[0], 0);
      chk("wrap_a1", a2[1], 128);
      chk("wrap_a2", a2[2], 0);
      chk("wrap_pass", pass_cnt2, 3);
      chk("wrap_errcnt", err_cnt2, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
